icache: RTL and testbench

//  Direct-mapped, one-word-per-line instruction cache between the IF stage and mem_ctrl.

---
 rtl/icache_pkg.sv | 14 +
 rtl/icache_if.sv | 15 +
 rtl/icache_array.sv | 34 +++
 rtl/icache.sv | 94 +++++++++
 tb/tb_icache.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/icache_pkg.sv
// icache_pkg: shared geometry, FSM encoding and address slicing for the instruction cache
//   INDEX_BITS : log2(line count), 64 lines of one 32-bit word each
//   TAG_BITS   : remaining word-address bits above the index
package icache_pkg;
  localparam int INDEX_BITS = 6;
  localparam int TAG_BITS = 30 - INDEX_BITS;
  typedef enum logic {IDLE, MISS} state_e;
  function automatic logic [INDEX_BITS-1:0] pc_index(input logic [31:0] pc);
    return pc[INDEX_BITS+1:2];
  endfunction
  function automatic logic [TAG_BITS-1:0] pc_tag(input logic [31:0] pc);
    return pc[31:INDEX_BITS+2];
  endfunction
endpackage

// File: rtl/icache_if.sv
// icache_if: IF-stage fetch handshake plus mem_ctrl read handshake
//   slave  : cache side (takes fetch requests and memory replies, drives answers and mem requests)
//   master : IF stage / mem_ctrl side
interface icache_if;
  logic        flush, fetch_valid, fetch_ready, mem_rn, mem_ready;
  logic [31:0] fetch_pc, fetch_inst, mem_pc, mem_value;
  modport slave (
    input  flush, fetch_valid, fetch_pc, mem_ready, mem_value,
    output fetch_ready, fetch_inst, mem_rn, mem_pc
  );
  modport master (
    output flush, fetch_valid, fetch_pc, mem_ready, mem_value,
    input  fetch_ready, fetch_inst, mem_rn, mem_pc
  );
endinterface

// File: rtl/icache_array.sv
// icache_array: valid bits (async cleared) plus unreset tag/data storage
//   clk, rst_n              : clock, async active-low reset (valid bits only)
//   we_i, widx_i, wtag_i, wdata_i : single write port (line fill)
//   ridx_i -> rvalid_o, rtag_o, rdata_o : combinational read port
module icache_array
  import icache_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we_i,
  input  logic [INDEX_BITS-1:0] widx_i,
  input  logic [TAG_BITS-1:0]   wtag_i,
  input  logic [31:0]           wdata_i,
  input  logic [INDEX_BITS-1:0] ridx_i,
  output logic                  rvalid_o,
  output logic [TAG_BITS-1:0]   rtag_o,
  output logic [31:0]           rdata_o
);
  localparam int LINES = 1 << INDEX_BITS;
  logic [LINES-1:0]    valid_q;
  logic [TAG_BITS-1:0] tag_q [LINES];
  logic [31:0]         data_q [LINES];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) valid_q <= '0;
    else if (we_i) valid_q[widx_i] <= 1'b1;
  always_ff @(posedge clk)
    if (we_i) begin
      tag_q[widx_i]  <= wtag_i;
      data_q[widx_i] <= wdata_i;
    end
  assign rvalid_o = valid_q[ridx_i];
  assign rtag_o   = tag_q[ridx_i];
  assign rdata_o  = data_q[ridx_i];
endmodule

// File: rtl/icache.sv
// icache: direct-mapped one-word-per-line instruction cache between IF and mem_ctrl
//   clk, rst_n : clock, async active-low reset
//   rdy        : global ready, low freezes all state and outputs
//   bus        : icache_if.slave (fetch handshake + mem_ctrl read handshake)
//   hit_cnt, miss_cnt : accepted hit/miss counters, present only with ICACHE_STATS_EN
module icache
  import icache_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rdy,
  icache_if.slave     bus
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
`endif
);
  state_e              state_q, state_d;
  logic                drop_q, drop_d, fetch_ready_q, fetch_ready_d, mem_rn_q, mem_rn_d;
  logic [31:0]         fetch_inst_q, fetch_inst_d, mem_pc_q, mem_pc_d;
  logic                rvalid, hit, accept, fill;
  logic [TAG_BITS-1:0] rtag;
  logic [31:0]         rdata;
  // mem_pc_q doubles as the latched miss address used for the fill
  icache_array u_array (
    .clk(clk), .rst_n(rst_n), .we_i(rdy && fill),
    .widx_i(pc_index(mem_pc_q)), .wtag_i(pc_tag(mem_pc_q)), .wdata_i(bus.mem_value),
    .ridx_i(pc_index(bus.fetch_pc)), .rvalid_o(rvalid), .rtag_o(rtag), .rdata_o(rdata)
  );
  assign hit    = rvalid && rtag == pc_tag(bus.fetch_pc);
  // the cycle showing fetch_ready still sees the held pc, so it must not answer again
  assign accept = state_q == IDLE && bus.fetch_valid && !fetch_ready_q && !bus.flush;
  assign fill   = state_q == MISS && bus.mem_ready;
  always_comb begin
    state_d       = state_q;
    drop_d        = drop_q;
    fetch_ready_d = 1'b0;
    fetch_inst_d  = fetch_inst_q;
    mem_rn_d      = mem_rn_q;
    mem_pc_d      = mem_pc_q;
    if (accept && hit) begin
      fetch_ready_d = 1'b1;
      fetch_inst_d  = rdata;
    end
    if (accept && !hit) begin
      state_d  = MISS;
      mem_rn_d = 1'b1;
      mem_pc_d = {bus.fetch_pc[31:2], 2'b00};
      drop_d   = 1'b0;
    end
    if (fill) begin
      state_d       = IDLE;
      mem_rn_d      = 1'b0;
      fetch_ready_d = !(drop_q || bus.flush);
      fetch_inst_d  = fetch_ready_d ? bus.mem_value : fetch_inst_q;
    end else if (state_q == MISS && bus.flush) begin
      drop_d = 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q       <= IDLE;
      drop_q        <= 1'b0;
      fetch_ready_q <= 1'b0;
      fetch_inst_q  <= '0;
      mem_rn_q      <= 1'b0;
      mem_pc_q      <= '0;
    end else if (rdy) begin
      state_q       <= state_d;
      drop_q        <= drop_d;
      fetch_ready_q <= fetch_ready_d;
      fetch_inst_q  <= fetch_inst_d;
      mem_rn_q      <= mem_rn_d;
      mem_pc_q      <= mem_pc_d;
    end
  assign bus.fetch_ready = fetch_ready_q;
  assign bus.fetch_inst  = fetch_inst_q;
  assign bus.mem_rn      = mem_rn_q;
  assign bus.mem_pc      = mem_pc_q;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (rdy && accept) begin
      hit_cnt_q  <= hit_cnt_q + 32'(hit);
      miss_cnt_q <= miss_cnt_q + 32'(!hit);
    end
  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif
endmodule

// File: tb/tb_icache.sv
// tb_icache: scoreboard bench for icache (miss, hit, conflict, flush, rdy freeze, async reset)
module tb_icache;
  logic clk, rst_n, rdy;
  int n_cmp = 0, n_bad = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp;
  bit ok;
  icache_if bus();
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt, miss_cnt;
`endif
  icache dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .bus(bus)
`ifdef ICACHE_STATS_EN
    , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
  );
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  task automatic step();
    @(negedge clk);
  endtask
  task automatic req(input logic [31:0] pc);
    bus.fetch_valid = 1'b1;
    bus.fetch_pc = pc;
  endtask
  task automatic mem_serve(input logic [31:0] v, input int delay, output bit served);
    int i = 0;
    while (!bus.mem_rn && i < 20) begin
      @(negedge clk);
      i++;
    end
    served = bus.mem_rn;
    if (served) begin
      repeat (delay) @(negedge clk);
      bus.mem_ready = 1'b1;
      bus.mem_value = v;
      @(negedge clk);
      bus.mem_ready = 1'b0;
    end
  endtask
  task automatic test_reset();
    repeat (2) step();
    if (bus.fetch_ready !== 1'b0) begin n_bad++; $display("FAIL reset_fetch_ready got=%b exp=0", bus.fetch_ready); end n_cmp++;
    if (bus.fetch_inst !== 32'h0) begin n_bad++; $display("FAIL reset_fetch_inst got=%h exp=0", bus.fetch_inst); end n_cmp++;
    if (bus.mem_rn !== 1'b0) begin n_bad++; $display("FAIL reset_mem_rn got=%b exp=0", bus.mem_rn); end n_cmp++;
    if (bus.mem_pc !== 32'h0) begin n_bad++; $display("FAIL reset_mem_pc got=%h exp=0", bus.mem_pc); end n_cmp++;
    rst_n = 1'b1;
  endtask
  task automatic test_cold_miss();
    req(32'h1000);
    exp_q.push_back(32'h00500093);
    step();
    if (bus.mem_rn !== 1'b1) begin n_bad++; $display("FAIL cold_mem_rn got=%b exp=1", bus.mem_rn); end n_cmp++;
    if (bus.mem_pc !== 32'h1000) begin n_bad++; $display("FAIL cold_mem_pc got=%h exp=00001000", bus.mem_pc); end n_cmp++;
    if (bus.fetch_ready !== 1'b0) begin n_bad++; $display("FAIL cold_early_ready got=%b exp=0", bus.fetch_ready); end n_cmp++;
    mem_serve(32'h00500093, 7, ok);
    if (ok !== 1'b1) begin n_bad++; $display("FAIL cold_served got=%b exp=1", ok); end n_cmp++;
    if (bus.fetch_ready !== 1'b1) begin n_bad++; $display("FAIL cold_ready got=%b exp=1", bus.fetch_ready); end n_cmp++;
    exp = exp_q.size() != 0 ? exp_q.pop_front() : 32'hx;
    if (bus.fetch_inst !== exp) begin n_bad++; $display("FAIL cold_inst got=%h exp=%h", bus.fetch_inst, exp); end n_cmp++;
    if (bus.mem_rn !== 1'b0) begin n_bad++; $display("FAIL cold_mem_rn_drop got=%b exp=0", bus.mem_rn); end n_cmp++;
    bus.fetch_valid = 1'b0;
    step();
    if (bus.fetch_ready !== 1'b0) begin n_bad++; $display("FAIL cold_pulse got=%b exp=0", bus.fetch_ready); end n_cmp++;
  endtask
  task automatic test_hit();
    req(32'h1002);
    exp_q.push_back(32'h00500093);
    step();
    if (bus.fetch_ready !== 1'b1) begin n_bad++; $display("FAIL hit_ready got=%b exp=1", bus.fetch_ready); end n_cmp++;
    exp = exp_q.size() != 0 ? exp_q.pop_front() : 32'hx;
    if (bus.fetch_inst !== exp) begin n_bad++; $display("FAIL hit_inst got=%h exp=%h", bus.fetch_inst, exp); end n_cmp++;
    if (bus.mem_rn !== 1'b0) begin n_bad++; $display("FAIL hit_mem_rn got=%b exp=0", bus.mem_rn); end n_cmp++;
    bus.fetch_valid = 1'b0;
    step();
  endtask
  task automatic test_back_to_back();
    logic pat [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    req(32'h1000);
    for (int i = 0; i < 4; i++) begin
      step();
      if (bus.fetch_ready !== pat[i]) begin n_bad++; $display("FAIL b2b_ready[%0d] got=%b exp=%b", i, bus.fetch_ready, pat[i]); end n_cmp++;
    end
    bus.fetch_valid = 1'b0;
    step();
  endtask
  task automatic test_conflict();
    req(32'h1100);
    exp_q.push_back(32'hDEAD0001);
    step();
    if (bus.mem_rn !== 1'b1 || bus.mem_pc !== 32'h1100) begin n_bad++; $display("FAIL conflict_miss got=%b/%h exp=1/00001100", bus.mem_rn, bus.mem_pc); end n_cmp++;
    mem_serve(32'hDEAD0001, 2, ok);
    exp = exp_q.size() != 0 ? exp_q.pop_front() : 32'hx;
    if (!ok || bus.fetch_ready !== 1'b1 || bus.fetch_inst !== exp) begin n_bad++; $display("FAIL conflict_fill got=%b/%h exp=1/%h", bus.fetch_ready, bus.fetch_inst, exp); end n_cmp++;
    bus.fetch_valid = 1'b0;
    step();
    req(32'h1000);
    exp_q.push_back(32'h00500093);
    step();
    if (bus.mem_rn !== 1'b1 || bus.mem_pc !== 32'h1000 || bus.fetch_ready !== 1'b0) begin n_bad++; $display("FAIL conflict_remiss got=%b/%h/%b exp=1/00001000/0", bus.mem_rn, bus.mem_pc, bus.fetch_ready); end n_cmp++;
    mem_serve(32'h00500093, 1, ok);
    exp = exp_q.size() != 0 ? exp_q.pop_front() : 32'hx;
    if (!ok || bus.fetch_ready !== 1'b1 || bus.fetch_inst !== exp) begin n_bad++; $display("FAIL conflict_refill got=%b/%h exp=1/%h", bus.fetch_ready, bus.fetch_inst, exp); end n_cmp++;
    bus.fetch_valid = 1'b0;
    step();
  endtask
  task automatic test_flush();
    req(32'h2040);
    step();
    if (bus.mem_rn !== 1'b1) begin n_bad++; $display("FAIL flush_mem_rn got=%b exp=1", bus.mem_rn); end n_cmp++;
    step();
    step();
    bus.flush = 1'b1;
    bus.fetch_valid = 1'b0;
    step();
    bus.flush = 1'b0;
    if (bus.mem_rn !== 1'b1 || bus.fetch_ready !== 1'b0) begin n_bad++; $display("FAIL flush_held got=%b/%b exp=1/0", bus.mem_rn, bus.fetch_ready); end n_cmp++;
    mem_serve(32'h11112222, 2, ok);
    if (!ok || bus.fetch_ready !== 1'b0 || bus.mem_rn !== 1'b0) begin n_bad++; $display("FAIL flush_dropped got=%b/%b exp=0/0", bus.fetch_ready, bus.mem_rn); end n_cmp++;
    step();
    req(32'h2040);
    exp_q.push_back(32'h11112222);
    step();
    exp = exp_q.size() != 0 ? exp_q.pop_front() : 32'hx;
    if (bus.fetch_ready !== 1'b1 || bus.fetch_inst !== exp || bus.mem_rn !== 1'b0) begin n_bad++; $display("FAIL flush_rehit got=%b/%h/%b exp=1/%h/0", bus.fetch_ready, bus.fetch_inst, bus.mem_rn, exp); end n_cmp++;
    bus.fetch_valid = 1'b0;
    step();
    req(32'h3080);
    step();
    if (bus.mem_rn !== 1'b1) begin n_bad++; $display("FAIL coflush_mem_rn got=%b exp=1", bus.mem_rn); end n_cmp++;
    step();
    bus.mem_ready = 1'b1;
    bus.mem_value = 32'h33334444;
    bus.flush = 1'b1;
    bus.fetch_valid = 1'b0;
    step();
    bus.mem_ready = 1'b0;
    bus.flush = 1'b0;
    if (bus.fetch_ready !== 1'b0 || bus.mem_rn !== 1'b0) begin n_bad++; $display("FAIL coflush_dropped got=%b/%b exp=0/0", bus.fetch_ready, bus.mem_rn); end n_cmp++;
    req(32'h3080);
    exp_q.push_back(32'h33334444);
    step();
    exp = exp_q.size() != 0 ? exp_q.pop_front() : 32'hx;
    if (bus.fetch_ready !== 1'b1 || bus.fetch_inst !== exp) begin n_bad++; $display("FAIL coflush_rehit got=%b/%h exp=1/%h", bus.fetch_ready, bus.fetch_inst, exp); end n_cmp++;
    bus.fetch_valid = 1'b0;
    step();
    req(32'h3080);
    bus.flush = 1'b1;
    step();
    if (bus.fetch_ready !== 1'b0 || bus.mem_rn !== 1'b0) begin n_bad++; $display("FAIL idle_flush got=%b/%b exp=0/0", bus.fetch_ready, bus.mem_rn); end n_cmp++;
    bus.flush = 1'b0;
    exp_q.push_back(32'h33334444);
    step();
    exp = exp_q.size() != 0 ? exp_q.pop_front() : 32'hx;
    if (bus.fetch_ready !== 1'b1 || bus.fetch_inst !== exp) begin n_bad++; $display("FAIL idle_flush_after got=%b/%h exp=1/%h", bus.fetch_ready, bus.fetch_inst, exp); end n_cmp++;
    bus.fetch_valid = 1'b0;
    step();
  endtask
  task automatic test_rdy();
    req(32'h4004);
    step();
    if (bus.mem_rn !== 1'b1) begin n_bad++; $display("FAIL rdy_mem_rn got=%b exp=1", bus.mem_rn); end n_cmp++;
    rdy = 1'b0;
    step();
    bus.mem_ready = 1'b1;
    bus.mem_value = 32'h55556666;
    step();
    bus.mem_ready = 1'b0;
    repeat (3) step();
    if (bus.mem_rn !== 1'b1 || bus.fetch_ready !== 1'b0) begin n_bad++; $display("FAIL rdy_frozen got=%b/%b exp=1/0", bus.mem_rn, bus.fetch_ready); end n_cmp++;
    rdy = 1'b1;
    exp_q.push_back(32'h55556666);
    mem_serve(32'h55556666, 1, ok);
    exp = exp_q.size() != 0 ? exp_q.pop_front() : 32'hx;
    if (!ok || bus.fetch_ready !== 1'b1 || bus.fetch_inst !== exp) begin n_bad++; $display("FAIL rdy_resume got=%b/%h exp=1/%h", bus.fetch_ready, bus.fetch_inst, exp); end n_cmp++;
    rdy = 1'b0;
    step();
    if (bus.fetch_ready !== 1'b1) begin n_bad++; $display("FAIL rdy_hold_ready got=%b exp=1", bus.fetch_ready); end n_cmp++;
    rdy = 1'b1;
    bus.fetch_valid = 1'b0;
    step();
    if (bus.fetch_ready !== 1'b0) begin n_bad++; $display("FAIL rdy_release got=%b exp=0", bus.fetch_ready); end n_cmp++;
  endtask
  task automatic test_reset_mid_miss();
    req(32'h5008);
    step();
    if (bus.mem_rn !== 1'b1) begin n_bad++; $display("FAIL rst_pre_mem_rn got=%b exp=1", bus.mem_rn); end n_cmp++;
    #2 rst_n = 1'b0;
    #1;
    if (bus.mem_rn !== 1'b0 || bus.fetch_ready !== 1'b0 || bus.mem_pc !== 32'h0) begin n_bad++; $display("FAIL rst_async got=%b/%b/%h exp=0/0/0", bus.mem_rn, bus.fetch_ready, bus.mem_pc); end n_cmp++;
    bus.fetch_valid = 1'b0;
    step();
    rst_n = 1'b1;
    req(32'h1000);
    exp_q.push_back(32'h00500093);
    step();
    if (bus.mem_rn !== 1'b1 || bus.fetch_ready !== 1'b0) begin n_bad++; $display("FAIL rst_cold_again got=%b/%b exp=1/0", bus.mem_rn, bus.fetch_ready); end n_cmp++;
    mem_serve(32'h00500093, 1, ok);
    exp = exp_q.size() != 0 ? exp_q.pop_front() : 32'hx;
    if (!ok || bus.fetch_ready !== 1'b1 || bus.fetch_inst !== exp) begin n_bad++; $display("FAIL rst_refill got=%b/%h exp=1/%h", bus.fetch_ready, bus.fetch_inst, exp); end n_cmp++;
    bus.fetch_valid = 1'b0;
    step();
`ifdef ICACHE_STATS_EN
    if (hit_cnt !== 32'd0 || miss_cnt !== 32'd1) begin n_bad++; $display("FAIL stats got=%0d/%0d exp=0/1", hit_cnt, miss_cnt); end n_cmp++;
`endif
  endtask
  initial begin
    clk = 1'b0;
    rst_n = 1'b0;
    rdy = 1'b1;
    bus.flush = 1'b0;
    bus.fetch_valid = 1'b0;
    bus.fetch_pc = '0;
    bus.mem_ready = 1'b0;
    bus.mem_value = '0;
    test_reset();
    test_cold_miss();
    test_hit();
    test_back_to_back();
    test_conflict();
    test_flush();
    test_rdy();
    test_reset_mid_miss();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
